dvi_timing_ctrl: RTL and testbench



---
 rtl/dvi_timing_ctrl.sv | 85 ++++++++
 tb/tb_dvi_timing_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster timing and pixel scheduler feeding the three TMDS encoders of a DVI transmitter
// Ports: clkin pixel clock; rstin synchronous active-high reset; en raster enable;
//   pix_data/pix_valid/pix_ready upstream pixel handshake; underflow_clr clears underflow;
//   red_din/green_din/blue_din, de, c0 (hsync), c1 (vsync) registered encoder inputs;
//   frame_start/line_start first-active-pixel pulses; underflow sticky flag; running raster active.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 12
) (
  input  logic        clkin,
  input  logic        rstin,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic [7:0]  red_din,
  output logic [7:0]  green_din,
  output logic [7:0]  blue_din,
  output logic        de,
  output logic        c0,
  output logic        c1,
  output logic        frame_start,
  output logic        line_start,
  output logic        underflow,
  output logic        running
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_A  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_F = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_L = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_L  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_A  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_F = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_L = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_L  = CW'(V_TOTAL - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] h_cnt, v_cnt;
  logic active, hs_act, vs_act, h_last, v_last;
  assign running = state == RUN;
  assign active  = h_cnt < H_A && v_cnt < V_A;
  assign hs_act  = h_cnt >= HS_F && h_cnt <= HS_L;
  assign vs_act  = v_cnt >= VS_F && v_cnt <= VS_L;
  assign h_last  = h_cnt == H_L;
  assign v_last  = v_cnt == V_L;
  // a pixel offered while reset is asserted must not be consumed
  assign pix_ready = running && active && !rstin;
  always_ff @(posedge clkin) begin
    if (rstin) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      de          <= 1'b0;
      c0          <= ~HS_POL;
      c1          <= ~VS_POL;
      {red_din, green_din, blue_din} <= 24'd0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      de          <= pix_ready;
      c0          <= (running && hs_act) ? HS_POL : ~HS_POL;
      c1          <= (running && vs_act) ? VS_POL : ~VS_POL;
      {red_din, green_din, blue_din} <= (pix_ready && pix_valid) ? pix_data : 24'd0;
      frame_start <= running && h_cnt == '0 && v_cnt == '0;
      line_start  <= running && h_cnt == '0 && v_cnt < V_A;
      underflow   <= (pix_ready && !pix_valid) || (underflow && !underflow_clr);
      // a frame in progress always completes; IDLE is only entered on its last pixel
      state       <= (running ? !(h_last && v_last && !en) : en) ? RUN : IDLE;
      h_cnt       <= (running && !h_last) ? h_cnt + 1'b1 : '0;
      v_cnt       <= !running ? '0 : h_last ? (v_last ? '0 : v_cnt + 1'b1) : v_cnt;
    end
  end
endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl: self-checking bench for dvi_timing_ctrl on an 8x6 raster
module tb_dvi_timing_ctrl;
  logic clkin = 1'b0, rstin = 1'b1, en = 1'b0, pix_valid = 1'b0, underflow_clr = 1'b0;
  logic [23:0] pix_data;
  logic pix_ready, de, c0, c1, frame_start, line_start, underflow, running;
  logic [7:0] red_din, green_din, blue_din;
  int checks = 0, errors = 0;
  logic chk_on = 1'b0;
  always #5 clkin = ~clkin;

  dvi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .CW(4)
  ) dut (
    .clkin(clkin), .rstin(rstin), .en(en),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .underflow_clr(underflow_clr),
    .red_din(red_din), .green_din(green_din), .blue_din(blue_din),
    .de(de), .c0(c0), .c1(c1),
    .frame_start(frame_start), .line_start(line_start),
    .underflow(underflow), .running(running)
  );

  task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // upstream source: the word advances only once the controller has taken it
  initial begin
    logic c;
    pix_data = 24'd1;
    forever begin
      @(negedge clkin);
      c = pix_valid && pix_ready;
      @(posedge clkin);
      #1;
      if (c) pix_data = pix_data + 24'd1;
    end
  end

  // model: a single frame position 0..47, decoded into line/column arithmetically
  logic m_run = 1'b0;
  int m_pos = 0;
  logic e_de = 1'b0, e_c0 = 1'b0, e_c1 = 1'b1, e_fs = 1'b0, e_ls = 1'b0, e_uf = 1'b0;
  logic [23:0] e_din = 24'd0;
  function automatic bit act_at(input int p);
    return (p % 8) < 4 && (p / 8) < 3;
  endfunction
  always @(posedge clkin) begin
    if (rstin) begin
      m_run <= 1'b0; m_pos <= 0; e_de <= 1'b0; e_c0 <= 1'b0; e_c1 <= 1'b1;
      e_fs <= 1'b0; e_ls <= 1'b0; e_uf <= 1'b0; e_din <= 24'd0;
    end else begin
      e_de  <= m_run && act_at(m_pos);
      e_c0  <= m_run && (m_pos % 8) >= 5 && (m_pos % 8) < 7;
      e_c1  <= !(m_run && (m_pos / 8) == 4);
      e_din <= (m_run && act_at(m_pos) && pix_valid) ? pix_data : 24'd0;
      e_ls  <= m_run && (m_pos % 8) == 0 && (m_pos / 8) < 3;
      e_fs  <= m_run && m_pos == 0;
      e_uf  <= (m_run && act_at(m_pos) && !pix_valid) || (e_uf && !underflow_clr);
      m_run <= m_run ? (m_pos != 47 || en) : en;
      m_pos <= (m_run && m_pos != 47) ? m_pos + 1 : 0;
    end
  end

  always @(negedge clkin) if (chk_on) begin
    cmp("pix_ready", {23'd0, pix_ready}, {23'd0, !rstin && m_run && act_at(m_pos)});
    cmp("de", {23'd0, de}, {23'd0, e_de});
    cmp("c0", {23'd0, c0}, {23'd0, e_c0});
    cmp("c1", {23'd0, c1}, {23'd0, e_c1});
    cmp("din", {red_din, green_din, blue_din}, e_din);
    cmp("frame_start", {23'd0, frame_start}, {23'd0, e_fs});
    cmp("line_start", {23'd0, line_start}, {23'd0, e_ls});
    cmp("underflow", {23'd0, underflow}, {23'd0, e_uf});
    cmp("running", {23'd0, running}, {23'd0, m_run});
  end

  task automatic nxt();
    @(posedge clkin);
    #1;
    @(negedge clkin);
  endtask

  task automatic wait_fs();
    int n = 0;
    @(negedge clkin);
    while (!frame_start && n < 100) begin
      nxt();
      n++;
    end
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout got 0 want 1 at %0t", $time);
    end
  endtask

  int nde, nc0, nc1l, nfs, nls, bseq, bad;
  logic c0_4, c0_5, c1_31, c1_32, run46, run47;

  initial begin
    repeat (3) @(posedge clkin);
    #1 chk_on = 1'b1;
    @(negedge clkin);
    cmp("rst_de", {23'd0, de}, 24'd0);
    cmp("rst_c0", {23'd0, c0}, 24'd0);
    cmp("rst_c1", {23'd0, c1}, 24'd1);
    cmp("rst_running", {23'd0, running}, 24'd0);
    @(posedge clkin);
    #1 rstin = 1'b0; en = 1'b1; pix_valid = 1'b1;
    // one full frame, indexed from the frame_start output cycle
    wait_fs();
    nde = 0; nc0 = 0; nc1l = 0; nfs = 0; nls = 0; bseq = 1; bad = 0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) nxt();
      if (de) begin
        if (blue_din !== 8'(bseq)) bad++;
        bseq++;
      end
      nde += int'(de); nc0 += int'(c0); nc1l += int'(!c1);
      nfs += int'(frame_start); nls += int'(line_start);
      if (i == 4) c0_4 = c0;
      if (i == 5) c0_5 = c0;
      if (i == 31) c1_31 = c1;
      if (i == 32) c1_32 = c1;
    end
    cmp("de_count", 24'(nde), 24'd12);
    cmp("blue_seq", 24'(bad), 24'd0);
    cmp("blue_last", 24'(bseq), 24'd13);
    cmp("c0_count", 24'(nc0), 24'd12);
    cmp("c0_before", {23'd0, c0_4}, 24'd0);
    cmp("c0_rise", {23'd0, c0_5}, 24'd1);
    cmp("c1_low_count", 24'(nc1l), 24'd8);
    cmp("c1_before", {23'd0, c1_31}, 24'd1);
    cmp("c1_fall", {23'd0, c1_32}, 24'd0);
    cmp("fs_count", 24'(nfs), 24'd1);
    cmp("ls_count", 24'(nls), 24'd3);
    nxt();
    cmp("fs_period", {23'd0, frame_start}, 24'd1);
    // starve pixel 2 of line 0
    @(posedge clkin); #1 pix_valid = 1'b0;
    @(posedge clkin); #1 pix_valid = 1'b1;
    @(negedge clkin);
    cmp("uf_slot_de", {23'd0, de}, 24'd1);
    cmp("uf_slot_din", {red_din, green_din, blue_din}, 24'd0);
    cmp("uf_flag", {23'd0, underflow}, 24'd1);
    nxt();
    cmp("uf_next_de", {23'd0, de}, 24'd1);
    cmp("uf_sticky", {23'd0, underflow}, 24'd1);
    @(posedge clkin); #1 underflow_clr = 1'b1;
    @(posedge clkin); #1 underflow_clr = 1'b0;
    @(negedge clkin);
    cmp("uf_cleared", {23'd0, underflow}, 24'd0);
    // clear and a fresh underflow in the same cycle
    wait_fs();
    @(posedge clkin); #1 pix_valid = 1'b0; underflow_clr = 1'b1;
    @(posedge clkin); #1 pix_valid = 1'b1; underflow_clr = 1'b0;
    @(negedge clkin);
    cmp("uf_set_wins", {23'd0, underflow}, 24'd1);
    @(posedge clkin); #1 underflow_clr = 1'b1;
    @(posedge clkin); #1 underflow_clr = 1'b0;
    // drop en at frame cycle 10: the frame still completes
    wait_fs();
    nde = 0;
    for (int i = 0; i < 48; i++) begin
      if (i > 0) begin
        @(posedge clkin);
        #1;
        if (i == 9) en = 1'b0;
        @(negedge clkin);
      end
      nde += int'(de);
      if (i == 46) run46 = running;
      if (i == 47) run47 = running;
    end
    cmp("drop_de_count", 24'(nde), 24'd12);
    cmp("drop_run46", {23'd0, run46}, 24'd1);
    cmp("drop_run47", {23'd0, run47}, 24'd0);
    bad = 0;
    repeat (20) begin
      nxt();
      if (de !== 1'b0 || c0 !== 1'b0 || c1 !== 1'b1 || running !== 1'b0) bad++;
    end
    cmp("idle_hold", 24'(bad), 24'd0);
    // reset mid-frame with en still high
    @(posedge clkin); #1 en = 1'b1;
    wait_fs();
    repeat (19) nxt();
    @(posedge clkin); #1 rstin = 1'b1;
    @(posedge clkin); #1 rstin = 1'b0;
    @(negedge clkin);
    cmp("mrst_de", {23'd0, de}, 24'd0);
    cmp("mrst_c0", {23'd0, c0}, 24'd0);
    cmp("mrst_c1", {23'd0, c1}, 24'd1);
    cmp("mrst_running", {23'd0, running}, 24'd0);
    nxt();
    cmp("restart_fs1", {23'd0, frame_start}, 24'd0);
    cmp("restart_run", {23'd0, running}, 24'd1);
    nxt();
    cmp("restart_fs2", {23'd0, frame_start}, 24'd1);
    cmp("restart_de", {23'd0, de}, 24'd1);
    repeat (10) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
